// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds single bytes from NUM_REQ requesters into one UART transmitter.
// Each requester owns a one-byte holding slot; one frame is launched at a time, with an idle clock between frames.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req_DV,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Full,
  output logic [NUM_REQ-1:0]   o_Req_Drop,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done,
  output logic [ID_W-1:0]      o_Grant_ID,
  output logic                 o_Busy
);

  // state         | meaning
  // S_IDLE        | waiting for a full slot and an idle line
  // S_LAUNCH      | strobe the selected byte into the UART, free its slot
  // S_WAIT_ACTIVE | waiting for the UART to report the frame started
  // S_WAIT_DONE   | frame on the wire, waiting for the done pulse
  // S_GAP         | one idle clock between frames
  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACTIVE,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_REQ-1:0][7:0]  slot_q, slot_d;
  logic [NUM_REQ-1:0]       full_q, full_d;
  logic [NUM_REQ-1:0]       drop_q, drop_d;
  logic [ID_W-1:0]          sel_q, sel_d;
  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [ID_W-1:0]          grant_q, grant_d;
  logic                     tx_dv_q, tx_dv_d;
  logic [7:0]               tx_byte_q, tx_byte_d;
  logic                     busy_q;
  logic [ID_W-1:0]          rr_idx;
  logic                     rr_found;
  logic                     launch;

  function automatic logic [ID_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Search starts just after the last grant, so a busy requester cannot starve the others.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rr_found && full_q[wrap_idx(int'(ptr_q), i + 1)]) begin
        rr_idx   = wrap_idx(int'(ptr_q), i + 1);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    launch    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rr_found && !i_TX_Active) begin
          sel_d   = rr_idx;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!i_TX_Active) begin
          launch    = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = slot_q[sel_q];
          grant_d   = sel_q;
          ptr_d     = sel_q;
          state_d   = S_WAIT_ACTIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_ACTIVE: if (i_TX_Active) state_d = S_WAIT_DONE;
      S_WAIT_DONE:   if (i_TX_Done) state_d = S_GAP;
      S_GAP:         state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // A write landing in the slot's own launch cycle refills it instead of being dropped.
  always_comb begin
    slot_d = slot_q;
    full_d = full_q;
    drop_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_Req_DV[k]) begin
        if (!full_q[k] || (launch && (sel_q == ID_W'(k)))) begin
          slot_d[k] = i_Req_Byte[8*k +: 8];
          full_d[k] = 1'b1;
        end else begin
          drop_d[k] = 1'b1;
        end
      end else if (launch && (sel_q == ID_W'(k))) begin
        full_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      slot_q    <= '0;
      full_q    <= '0;
      drop_q    <= '0;
      sel_q     <= '0;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      grant_q   <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      full_q    <= full_d;
      drop_q    <= drop_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign o_Req_Full = full_q;
  assign o_Req_Drop = drop_q;
  assign o_TX_DV    = tx_dv_q;
  assign o_TX_Byte  = tx_byte_q;
  assign o_Grant_ID = grant_q;
  assign o_Busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART transmitter and receiver on a looped serial line,
// with expected launches/bytes queued at stimulus time and popped when frames come out.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CPB     = 217;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_dv = '0;
  logic [8*NUM_REQ-1:0] req_byte = '0;
  logic                 tx_active = 1'b0;
  logic                 tx_done = 1'b0;
  logic [NUM_REQ-1:0]   o_Req_Full, o_Req_Drop;
  logic                 o_TX_DV, o_Busy;
  logic [7:0]           o_TX_Byte;
  logic [ID_W-1:0]      o_Grant_ID;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Req_DV(req_dv), .i_Req_Byte(req_byte),
    .o_Req_Full(o_Req_Full), .o_Req_Drop(o_Req_Drop), .o_TX_DV(o_TX_DV),
    .o_TX_Byte(o_TX_Byte), .i_TX_Active(tx_active), .i_TX_Done(tx_done),
    .o_Grant_ID(o_Grant_ID), .o_Busy(o_Busy)
  );

  always #20 clk = ~clk;

  typedef struct packed { logic [1:0] id; logic [7:0] data; } item_t;

  int    checks = 0;
  int    fails = 0;
  int    cyc = 0;
  item_t exp_q[$];
  item_t launch_q[$];
  logic [7:0] rx_q[$];
  logic  serial = 1'b1;
  int    tx_bit = -1;
  int    dv_busy_cnt = 0;
  int    stop_end_cyc = -100000;
  int    min_gap = 1000000;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: not reset by the arbiter, keeps sending through a reset.
  initial begin : tx_model
    logic [7:0] b;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (o_TX_DV === 1'b1) begin
        b = o_TX_Byte;
        launch_q.push_back(item_t'({o_Grant_ID, o_TX_Byte}));
        if (cyc - stop_end_cyc < min_gap) min_gap = cyc - stop_end_cyc;
        tx_active = 1'b1;
        for (int bi = 0; bi < 10; bi++) begin
          tx_bit = bi;
          serial = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
          repeat (CPB) begin
            @(negedge clk);
            if (o_TX_DV === 1'b1) dv_busy_cnt++;
          end
        end
        tx_done = 1'b1;
        tx_active = 1'b0;
        tx_bit = -1;
        stop_end_cyc = cyc;
      end
    end
  end

  initial begin : rx_model
    logic [7:0] d;
    forever begin
      @(negedge serial);
      repeat (CPB/2) @(posedge clk);
      if (serial == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          d[i] = serial;
        end
        repeat (CPB) @(posedge clk);
        if (serial == 1'b1) rx_q.push_back(d);
      end
    end
  end

  initial begin : watchdog
    #3600000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_q.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (rx_q.size() >= n) ok = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (!o_Busy && !tx_active) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic apply_reset();
    req_dv = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (o_Req_Full !== 4'h0) begin fails++; $display("FAIL reset_full: got %b want 0000", o_Req_Full); end
    checks++; if (o_Req_Drop !== 4'h0) begin fails++; $display("FAIL reset_drop: got %b want 0000", o_Req_Drop); end
    checks++; if (o_TX_DV !== 1'b0) begin fails++; $display("FAIL reset_txdv: got %b want 0", o_TX_DV); end
    checks++; if (o_TX_Byte !== 8'h00) begin fails++; $display("FAIL reset_byte: got %h want 00", o_TX_Byte); end
    checks++; if (o_Grant_ID !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d want 0", o_Grant_ID); end
    checks++; if (o_Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", o_Busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    req_byte[23:16] = 8'h3F; req_dv = 4'b0100;
    exp_q.push_back(item_t'({2'd2, 8'h3F}));
    @(negedge clk); req_dv = '0;
    checks++; if (o_Req_Full[2] !== 1'b1) begin fails++; $display("FAIL single_full: got %b want 1", o_Req_Full[2]); end
    checks++; if (o_TX_DV !== 1'b0) begin fails++; $display("FAIL single_dv_early1: got %b want 0", o_TX_DV); end
    @(negedge clk);
    checks++; if (o_TX_DV !== 1'b0) begin fails++; $display("FAIL single_dv_early2: got %b want 0", o_TX_DV); end
    checks++; if (o_Busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", o_Busy); end
    @(negedge clk);
    checks++; if (o_TX_DV !== 1'b1) begin fails++; $display("FAIL single_dv_latency: got %b want 1", o_TX_DV); end
    checks++; if (o_TX_Byte !== 8'h3F) begin fails++; $display("FAIL single_byte: got %h want 3f", o_TX_Byte); end
    checks++; if (o_Grant_ID !== 2'd2) begin fails++; $display("FAIL single_grant: got %0d want 2", o_Grant_ID); end
    checks++; if (o_Req_Full[2] !== 1'b0) begin fails++; $display("FAIL single_cleared: got %b want 0", o_Req_Full[2]); end
    @(negedge clk);
    checks++; if (o_TX_DV !== 1'b0) begin fails++; $display("FAIL single_dv_width: got %b want 0", o_TX_DV); end
    wait_rx(1, 4000, ok);
    checks++; if (!ok) begin fails++; $display("FAIL single_rx_timeout: got %0d bytes want 1", rx_q.size()); end
    while (exp_q.size() > 0) begin
      item_t e, l; logic [7:0] r;
      e = exp_q.pop_front();
      checks++;
      if (launch_q.size() == 0) begin fails++; $display("FAIL single_launch: got none want %h", e); end
      else begin l = launch_q.pop_front(); if (l !== e) begin fails++; $display("FAIL single_launch: got %h want %h", l, e); end end
      checks++;
      if (rx_q.size() == 0) begin fails++; $display("FAIL single_rx: got none want %h", e.data); end
      else begin r = rx_q.pop_front(); if (r !== e.data) begin fails++; $display("FAIL single_rx: got %h want %h", r, e.data); end end
    end
    wait_idle(ok);
    checks++; if (o_TX_Byte !== 8'h3F || o_Grant_ID !== 2'd2) begin fails++; $display("FAIL single_hold: got %h/%0d want 3f/2", o_TX_Byte, o_Grant_ID); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    apply_reset();
    min_gap = 1000000;
    dv_busy_cnt = 0;
    req_byte = 32'h44332211; req_dv = 4'b1111;
    exp_q.push_back(item_t'({2'd0, 8'h11}));
    exp_q.push_back(item_t'({2'd1, 8'h22}));
    exp_q.push_back(item_t'({2'd2, 8'h33}));
    exp_q.push_back(item_t'({2'd3, 8'h44}));
    @(negedge clk); req_dv = '0;
    wait_rx(4, 12000, ok);
    checks++; if (!ok) begin fails++; $display("FAIL simul_rx_timeout: got %0d bytes want 4", rx_q.size()); end
    while (exp_q.size() > 0) begin
      item_t e, l; logic [7:0] r;
      e = exp_q.pop_front();
      checks++;
      if (launch_q.size() == 0) begin fails++; $display("FAIL simul_launch: got none want %h", e); end
      else begin l = launch_q.pop_front(); if (l !== e) begin fails++; $display("FAIL simul_launch: got %h want %h", l, e); end end
      checks++;
      if (rx_q.size() == 0) begin fails++; $display("FAIL simul_rx: got none want %h", e.data); end
      else begin r = rx_q.pop_front(); if (r !== e.data) begin fails++; $display("FAIL simul_rx: got %h want %h", r, e.data); end end
    end
    checks++; if (min_gap < 2) begin fails++; $display("FAIL simul_gap: got %0d cycles want >=2", min_gap); end
    checks++; if (dv_busy_cnt != 0) begin fails++; $display("FAIL simul_dv_while_active: got %0d want 0", dv_busy_cnt); end
    wait_idle(ok);
  endtask

  task automatic test_fairness();
    bit ok;
    bit seen;
    req_byte[7:0] = 8'h01; req_byte[31:24] = 8'h03; req_dv = 4'b1001;
    exp_q.push_back(item_t'({2'd0, 8'h01}));
    exp_q.push_back(item_t'({2'd3, 8'h03}));
    exp_q.push_back(item_t'({2'd0, 8'h02}));
    @(negedge clk); req_dv = '0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_TX_DV === 1'b1) begin seen = 1'b1; break; end
    end
    req_byte[7:0] = 8'h02; req_dv = 4'b0001;
    @(negedge clk); req_dv = '0;
    checks++; if (!seen) begin fails++; $display("FAIL fair_first_launch: got no launch want launch within 20 cycles"); end
    wait_rx(3, 9000, ok);
    checks++; if (!ok) begin fails++; $display("FAIL fair_rx_timeout: got %0d bytes want 3", rx_q.size()); end
    while (exp_q.size() > 0) begin
      item_t e, l; logic [7:0] r;
      e = exp_q.pop_front();
      checks++;
      if (launch_q.size() == 0) begin fails++; $display("FAIL fair_launch: got none want %h", e); end
      else begin l = launch_q.pop_front(); if (l !== e) begin fails++; $display("FAIL fair_launch: got %h want %h", l, e); end end
      checks++;
      if (rx_q.size() == 0) begin fails++; $display("FAIL fair_rx: got none want %h", e.data); end
      else begin r = rx_q.pop_front(); if (r !== e.data) begin fails++; $display("FAIL fair_rx: got %h want %h", r, e.data); end end
    end
    wait_idle(ok);
  endtask

  task automatic test_overflow();
    bit ok;
    int drops;
    req_byte[15:8] = 8'hA5; req_dv = 4'b0010;
    exp_q.push_back(item_t'({2'd1, 8'hA5}));
    @(negedge clk); req_byte[15:8] = 8'h5A;
    @(negedge clk); req_dv = '0;
    checks++; if (o_Req_Drop !== 4'b0010) begin fails++; $display("FAIL ovf_drop: got %b want 0010", o_Req_Drop); end
    drops = (o_Req_Drop[1] === 1'b1) ? 1 : 0;
    @(negedge clk);
    checks++; if (o_TX_DV !== 1'b1 || o_TX_Byte !== 8'hA5) begin fails++; $display("FAIL ovf_launch: got dv=%b byte=%h want dv=1 byte=a5", o_TX_DV, o_TX_Byte); end
    for (int i = 0; i < 6; i++) begin
      if (o_Req_Drop[1] === 1'b1) drops++;
      @(negedge clk);
    end
    checks++; if (drops != 1) begin fails++; $display("FAIL ovf_drop_count: got %0d want 1", drops); end
    wait_rx(1, 3000, ok);
    checks++; if (!ok) begin fails++; $display("FAIL ovf_rx_timeout: got %0d bytes want 1", rx_q.size()); end
    while (exp_q.size() > 0) begin
      item_t e, l; logic [7:0] r;
      e = exp_q.pop_front();
      checks++;
      if (launch_q.size() == 0) begin fails++; $display("FAIL ovf_launch_q: got none want %h", e); end
      else begin l = launch_q.pop_front(); if (l !== e) begin fails++; $display("FAIL ovf_launch_q: got %h want %h", l, e); end end
      checks++;
      if (rx_q.size() == 0) begin fails++; $display("FAIL ovf_rx: got none want %h", e.data); end
      else begin r = rx_q.pop_front(); if (r !== e.data) begin fails++; $display("FAIL ovf_rx: got %h want %h", r, e.data); end end
    end
    wait_idle(ok);
    checks++; if (o_Req_Full !== 4'h0 || launch_q.size() != 0) begin fails++; $display("FAIL ovf_no_second: got full=%b launches=%0d want 0000/0", o_Req_Full, launch_q.size()); end
  endtask

  task automatic test_launch_write();
    bit ok;
    req_byte[15:8] = 8'h77; req_dv = 4'b0010;
    exp_q.push_back(item_t'({2'd1, 8'h77}));
    exp_q.push_back(item_t'({2'd1, 8'hC3}));
    @(negedge clk); req_dv = '0;
    @(negedge clk); req_byte[15:8] = 8'hC3; req_dv = 4'b0010;
    @(negedge clk); req_dv = '0;
    checks++; if (o_TX_DV !== 1'b1 || o_TX_Byte !== 8'h77) begin fails++; $display("FAIL lw_launch: got dv=%b byte=%h want dv=1 byte=77", o_TX_DV, o_TX_Byte); end
    checks++; if (o_Req_Full[1] !== 1'b1) begin fails++; $display("FAIL lw_full: got %b want 1", o_Req_Full[1]); end
    checks++; if (o_Req_Drop !== 4'h0) begin fails++; $display("FAIL lw_drop: got %b want 0000", o_Req_Drop); end
    wait_rx(2, 6000, ok);
    checks++; if (!ok) begin fails++; $display("FAIL lw_rx_timeout: got %0d bytes want 2", rx_q.size()); end
    while (exp_q.size() > 0) begin
      item_t e, l; logic [7:0] r;
      e = exp_q.pop_front();
      checks++;
      if (launch_q.size() == 0) begin fails++; $display("FAIL lw_launch_q: got none want %h", e); end
      else begin l = launch_q.pop_front(); if (l !== e) begin fails++; $display("FAIL lw_launch_q: got %h want %h", l, e); end end
      checks++;
      if (rx_q.size() == 0) begin fails++; $display("FAIL lw_rx: got none want %h", e.data); end
      else begin r = rx_q.pop_front(); if (r !== e.data) begin fails++; $display("FAIL lw_rx: got %h want %h", r, e.data); end end
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    int early;
    req_byte[23:16] = 8'h96; req_byte[31:24] = 8'h69; req_dv = 4'b1100;
    @(negedge clk); req_dv = '0;
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_bit == 5) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin fails++; $display("FAIL rmid_bit4_timeout: got bit %0d want 5", tx_bit); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (o_Req_Full !== 4'h0 || o_Req_Drop !== 4'h0) begin fails++; $display("FAIL rmid_slots: got full=%b drop=%b want 0000/0000", o_Req_Full, o_Req_Drop); end
    checks++; if (o_TX_DV !== 1'b0 || o_TX_Byte !== 8'h00) begin fails++; $display("FAIL rmid_tx: got dv=%b byte=%h want 0/00", o_TX_DV, o_TX_Byte); end
    checks++; if (o_Grant_ID !== 2'd0 || o_Busy !== 1'b0) begin fails++; $display("FAIL rmid_state: got grant=%0d busy=%b want 0/0", o_Grant_ID, o_Busy); end
    rst_n = 1'b1;
    req_byte[7:0] = 8'hE1; req_byte[31:24] = 8'h3C; req_dv = 4'b1001;
    @(negedge clk); req_dv = '0;
    @(negedge clk);
    checks++; if (o_Req_Full !== 4'b1001) begin fails++; $display("FAIL rmid_refill: got %b want 1001", o_Req_Full); end
    early = 0;
    hit = 1'b0;
    for (int i = 0; i < 10*CPB + 20; i++) begin
      if (!tx_active) begin hit = 1'b1; break; end
      if (o_TX_DV === 1'b1) early++;
      @(negedge clk);
    end
    checks++; if (!hit) begin fails++; $display("FAIL rmid_active_timeout: got active=%b want 0", tx_active); end
    checks++; if (early != 0) begin fails++; $display("FAIL rmid_dv_while_active: got %0d pulses want 0", early); end
    rx_q.delete();
    launch_q.delete();
    exp_q.push_back(item_t'({2'd0, 8'hE1}));
    exp_q.push_back(item_t'({2'd3, 8'h3C}));
    wait_rx(2, 6000, ok);
    checks++; if (!ok) begin fails++; $display("FAIL rmid_rx_timeout: got %0d bytes want 2", rx_q.size()); end
    while (exp_q.size() > 0) begin
      item_t e, l; logic [7:0] r;
      e = exp_q.pop_front();
      checks++;
      if (launch_q.size() == 0) begin fails++; $display("FAIL rmid_launch: got none want %h", e); end
      else begin l = launch_q.pop_front(); if (l !== e) begin fails++; $display("FAIL rmid_launch: got %h want %h", l, e); end end
      checks++;
      if (rx_q.size() == 0) begin fails++; $display("FAIL rmid_rx: got none want %h", e.data); end
      else begin r = rx_q.pop_front(); if (r !== e.data) begin fails++; $display("FAIL rmid_rx: got %h want %h", r, e.data); end end
    end
    wait_idle(ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_overflow();
    test_launch_write();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
